// File: rtl/cpu_debug_pkg.sv
// Shared encodings for the CPU debug action scheduler: class/op codes,
// scheduler FSM states, default parameters and small strobe-decode helpers.
// Pure declarations; no logic, no latency, no flow control.
package cpu_debug_pkg;

    localparam int NUM_CLASS       = 4;
    localparam int JDO_W_DEFAULT   = 38;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        CLS_OCIMEM    = 2'd0,
        CLS_BREAK     = 2'd1,
        CLS_TRACEMEM  = 2'd2,
        CLS_TRACECTRL = 2'd3
    } cls_e;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_C = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Strobes of one class packed {c, b, a}; the lowest suffix wins.
    function automatic logic [1:0] lowest_op(input logic [2:0] s);
        if (s[0])      return OP_A;
        else if (s[1]) return OP_B;
        else           return OP_C;
    endfunction

    // True when two or more strobes of one class fire together.
    function automatic logic multi_hit(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/cpu_debug_action_sched_if.sv
// Command/response port between the debug action scheduler and the shared resource.
// master: scheduler side (drives cmd_*, receives cmd_ready and rsp_*).
// slave:  resource side; cmd accepted on cmd_valid & cmd_ready, rsp_valid is a one-cycle completion pulse.
interface cpu_debug_action_sched_if #(
    parameter int JDO_W = cpu_debug_pkg::JDO_W_DEFAULT
);
    logic             cmd_valid;
    logic [1:0]       cmd_class;
    logic [1:0]       cmd_op;
    logic [JDO_W-1:0] cmd_data;
    logic             cmd_ready;
    logic             rsp_valid;
    logic [31:0]      rsp_rdata;

    modport master (
        output cmd_valid, cmd_class, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_class, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/cpu_debug_rr_arb.sv
// Round-robin selector over the four command classes; search starts at ptr+1 (mod 4).
// Ports: req (pending slots), ptr (last served class) in; gnt (one-hot), idx (encoded) out.
// Purely combinational, zero latency; no backpressure (gnt is zero when req is zero).
module cpu_debug_rr_arb
    import cpu_debug_pkg::*;
(
    input  logic [NUM_CLASS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_CLASS-1:0] gnt,
    output logic [1:0]           idx
);

    logic       found;
    logic [1:0] cand;

    // Candidates in order ptr+1, ptr+2, ptr+3, ptr; 2-bit wrap gives the mod 4.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_CLASS; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_debug_action_sched.sv
// Captures debug take_action strobes into per-class one-entry slots and serialises them
// onto one shared command port (round-robin), waiting for completion or timeout.
// Ports: clk/reset, jdo + strobes in; cmd_if (master) to resource; done/done_class/done_rdata,
// timeout_err/ovf (sticky, cleared by clr_status), busy out.
// Latency: strobe -> cmd_valid >= 2 cycles. Backpressure: cmd_valid held with stable
// payload until cmd_ready; a strobe to an occupied slot is dropped and flagged in ovf.
module cpu_debug_action_sched
    import cpu_debug_pkg::*;
#(
    parameter int JDO_W   = JDO_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [JDO_W-1:0]        jdo,
    input  logic                    take_action_ocimem_a,
    input  logic                    take_action_ocimem_b,
    input  logic                    take_action_break_a,
    input  logic                    take_action_break_b,
    input  logic                    take_action_break_c,
    input  logic                    take_action_tracemem_a,
    input  logic                    take_action_tracemem_b,
    input  logic                    take_action_tracectrl,
    cpu_debug_action_sched_if.master cmd_if,
    output logic                    done,
    output logic [1:0]              done_class,
    output logic [31:0]             done_rdata,
    output logic                    timeout_err,
    output logic [3:0]              ovf,
    output logic                    busy,
    input  logic                    clr_status
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    // Strobe decode, one {c, b, a} group per class
    logic [NUM_CLASS-1:0][2:0] stb;
    logic [NUM_CLASS-1:0]      stb_any;
    logic [NUM_CLASS-1:0]      stb_multi;
    logic [NUM_CLASS-1:0][1:0] stb_op;

    assign stb[CLS_OCIMEM]    = {1'b0, take_action_ocimem_b, take_action_ocimem_a};
    assign stb[CLS_BREAK]     = {take_action_break_c, take_action_break_b, take_action_break_a};
    assign stb[CLS_TRACEMEM]  = {1'b0, take_action_tracemem_b, take_action_tracemem_a};
    assign stb[CLS_TRACECTRL] = {2'b00, take_action_tracectrl};

    always_comb begin
        stb_any   = '0;
        stb_multi = '0;
        stb_op    = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            stb_any[c]   = |stb[c];
            stb_multi[c] = multi_hit(stb[c]);
            stb_op[c]    = lowest_op(stb[c]);
        end
    end

    // Pending slots
    logic [NUM_CLASS-1:0]      slot_vld;
    logic [NUM_CLASS-1:0][1:0] slot_op;
    logic [JDO_W-1:0]          slot_dat [NUM_CLASS];

    // Scheduler state
    state_e           state_q;
    state_e           state_d;
    logic [1:0]       rr_ptr;
    logic [7:0]       wait_cnt;
    cls_e             sel_cls;
    logic [1:0]       sel_op;
    logic [JDO_W-1:0] sel_dat;

    logic [NUM_CLASS-1:0] arb_gnt;
    logic [1:0]           arb_idx;

    logic                 sel_load;
    logic                 hs;
    logic                 retire;
    logic                 rsp_done;
    logic                 to_hit;
    logic [NUM_CLASS-1:0] retire_vec;
    logic [NUM_CLASS-1:0] ovf_set;

    cpu_debug_rr_arb u_arb (
        .req (slot_vld),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        sel_load = 1'b0;
        hs       = 1'b0;
        retire   = 1'b0;
        rsp_done = 1'b0;
        to_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    sel_load = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_if.cmd_ready) begin
                    hs      = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response in the timeout cycle still counts as a completion.
                if (cmd_if.rsp_valid) begin
                    rsp_done = 1'b1;
                    retire   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (wait_cnt == TO_LIM) begin
                    to_hit  = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        retire_vec = '0;
        if (retire) retire_vec[sel_cls] = 1'b1;
    end

    // A slot being retired this cycle may be refilled without flagging overflow.
    always_comb begin
        ovf_set = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            ovf_set[c] = stb_multi[c] | (stb_any[c] & slot_vld[c] & ~retire_vec[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_vld    <= '0;
            slot_op     <= '0;
            rr_ptr      <= 2'd3;
            wait_cnt    <= '0;
            sel_cls     <= CLS_OCIMEM;
            sel_op      <= '0;
            sel_dat     <= '0;
            done        <= 1'b0;
            done_class  <= '0;
            done_rdata  <= '0;
            timeout_err <= 1'b0;
            ovf         <= '0;
            for (int c = 0; c < NUM_CLASS; c++) slot_dat[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                if (stb_any[c] && (!slot_vld[c] || retire_vec[c])) begin
                    slot_vld[c] <= 1'b1;
                    slot_op[c]  <= stb_op[c];
                    slot_dat[c] <= jdo;
                end else if (retire_vec[c]) begin
                    slot_vld[c] <= 1'b0;
                end
            end

            // The slot cannot change while it is valid, so a snapshot is stable for ISSUE.
            if (sel_load) begin
                sel_cls <= cls_e'(arb_idx);
                sel_op  <= slot_op[arb_idx];
                sel_dat <= slot_dat[arb_idx];
            end

            if (hs)                            wait_cnt <= 8'd1;
            else if (retire)                   wait_cnt <= '0;
            else if (state_q == ST_WAIT)       wait_cnt <= wait_cnt + 8'd1;

            if (retire) rr_ptr <= sel_cls;

            done <= rsp_done;
            if (rsp_done) begin
                done_class <= sel_cls;
                done_rdata <= cmd_if.rsp_rdata;
            end

            // Set events win over a simultaneous clear.
            timeout_err <= (timeout_err & ~clr_status) | to_hit;
            ovf         <= (ovf & {4{~clr_status}}) | ovf_set;
        end
    end

    assign cmd_if.cmd_valid = (state_q == ST_ISSUE);
    assign cmd_if.cmd_class = sel_cls;
    assign cmd_if.cmd_op    = sel_op;
    assign cmd_if.cmd_data  = sel_dat;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_debug_action_sched.sv
// Self-checking bench for cpu_debug_action_sched with a transaction-level slot/round-robin model.
// The bench plays the shared resource; inputs change and outputs are sampled on the falling edge.
// TIMEOUT is set to 4 so the abort path is reachable quickly.
module tb_cpu_debug_action_sched;
    import cpu_debug_pkg::*;

    localparam int JDO_W = 38;
    localparam int TO    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [JDO_W-1:0] jdo;
    logic [7:0]       stb;   // {tc, tm_b, tm_a, brk_c, brk_b, brk_a, oci_b, oci_a}
    logic             clr_status;
    logic             done;
    logic [1:0]       done_class;
    logic [31:0]      done_rdata;
    logic             timeout_err;
    logic [3:0]       ovf;
    logic             busy;

    always #5 clk = ~clk;

    cpu_debug_action_sched_if #(.JDO_W(JDO_W)) cif ();

    cpu_debug_action_sched #(.JDO_W(JDO_W), .TIMEOUT(TO)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (stb[0]),
        .take_action_ocimem_b   (stb[1]),
        .take_action_break_a    (stb[2]),
        .take_action_break_b    (stb[3]),
        .take_action_break_c    (stb[4]),
        .take_action_tracemem_a (stb[5]),
        .take_action_tracemem_b (stb[6]),
        .take_action_tracectrl  (stb[7]),
        .cmd_if                 (cif),
        .done                   (done),
        .done_class             (done_class),
        .done_rdata             (done_rdata),
        .timeout_err            (timeout_err),
        .ovf                    (ovf),
        .busy                   (busy),
        .clr_status             (clr_status)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: one pending entry per class, last-served pointer, sticky overflow.
    bit               m_vld [4];
    logic [1:0]       m_op  [4];
    logic [JDO_W-1:0] m_dat [4];
    int               m_rr;
    logic [3:0]       m_ovf;

    function automatic logic [JDO_W-1:0] rnd_jdo();
        return JDO_W'({$urandom(), $urandom()});
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_vld[c] = 1'b0; m_op[c] = '0; m_dat[c] = '0;
        end
        m_rr  = 3;
        m_ovf = '0;
    endtask

    task automatic model_strobe(input logic [7:0] s, input logic [JDO_W-1:0] d);
        int lo [4] = '{0, 2, 5, 7};
        int nb [4] = '{2, 3, 2, 1};
        for (int c = 0; c < 4; c++) begin
            int cnt = 0;
            int first = -1;
            for (int k = 0; k < nb[c]; k++) begin
                if (s[lo[c] + k]) begin
                    cnt++;
                    if (first < 0) first = k;
                end
            end
            if (cnt > 1) m_ovf[c] = 1'b1;
            if (cnt > 0) begin
                if (m_vld[c]) m_ovf[c] = 1'b1;
                else begin
                    m_vld[c] = 1'b1; m_op[c] = 2'(first); m_dat[c] = d;
                end
            end
        end
    endtask

    function automatic int model_next();
        for (int k = 1; k <= 4; k++) begin
            if (m_vld[(m_rr + k) % 4]) return (m_rr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_retire(input int c);
        m_vld[c] = 1'b0;
        m_rr     = c;
    endtask

    task automatic apply_strobes(input logic [7:0] s, input logic [JDO_W-1:0] d);
        model_strobe(s, d);
        stb = s;
        jdo = d;
        @(negedge clk);
        stb = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stb   = 8'($urandom());
        jdo   = rnd_jdo();
        cif.cmd_ready = 1'b0;
        cif.rsp_valid = 1'b0;
        clr_status    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        stb   = '0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        m_ovf = '0;
    endtask

    // Acts as the resource for one command and reports what it observed.
    task automatic serve_cmd(input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                             input bit give_rsp, output bit seen, output logic [1:0] cls,
                             output logic [1:0] op, output logic [JDO_W-1:0] dat,
                             output bit stable, output bit vld_after, output bit done_seen,
                             output logic [1:0] dcls, output logic [31:0] drd,
                             output bit to_early, output bit to_seen);
        int n = 0;
        seen = 0; cls = '0; op = '0; dat = '0; stable = 1; vld_after = 0;
        done_seen = 0; dcls = '0; drd = '0; to_early = 0; to_seen = 0;
        while (!cif.cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cif.cmd_valid) return;
        seen = 1; cls = cif.cmd_class; op = cif.cmd_op; dat = cif.cmd_data;
        for (int k = 0; k < rdy_dly; k++) begin
            @(negedge clk);
            if (!cif.cmd_valid || cif.cmd_class !== cls || cif.cmd_op !== op || cif.cmd_data !== dat)
                stable = 0;
        end
        cif.cmd_ready = 1'b1;
        @(negedge clk);
        cif.cmd_ready = 1'b0;
        vld_after = cif.cmd_valid;
        if (give_rsp) begin
            repeat (rsp_dly - 1) @(negedge clk);
            cif.rsp_valid = 1'b1;
            cif.rsp_rdata = rdata;
            @(negedge clk);
            cif.rsp_valid = 1'b0;
            done_seen = done; dcls = done_class; drd = done_rdata;
        end else begin
            repeat (TO - 1) @(negedge clk);
            to_early = timeout_err;
            @(negedge clk);
            to_seen = timeout_err; done_seen = done;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (cif.cmd_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_valid_busy: got %b%b, required 00", cif.cmd_valid, busy); else n_pass++;
        n_chk++; if ({cif.cmd_class, cif.cmd_op, cif.cmd_data} !== '0) $display("FAIL reset_cmd: got cls=%0d op=%0d dat=%h, required 0", cif.cmd_class, cif.cmd_op, cif.cmd_data); else n_pass++;
        n_chk++; if ({done, done_class, done_rdata} !== '0) $display("FAIL reset_done: got done=%b cls=%0d rd=%h, required 0", done, done_class, done_rdata); else n_pass++;
        n_chk++; if ({timeout_err, ovf} !== 5'b0) $display("FAIL reset_status: got terr=%b ovf=%b, required 0", timeout_err, ovf); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (cif.cmd_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_strobe_ignored: got valid=%b busy=%b, required 0 0", cif.cmd_valid, busy); else n_pass++;
    endtask

    task automatic test_single();
        bit seen, st, va, ds, te, ts; logic [1:0] cls, op, dcls; logic [JDO_W-1:0] dat; logic [31:0] drd;
        apply_strobes(8'h02, 38'h2A_DEADBEEF);
        n_chk++; if (cif.cmd_valid !== 1'b0) $display("FAIL latency_edge1: got cmd_valid=%b, required 0", cif.cmd_valid); else n_pass++;
        @(negedge clk);
        n_chk++; if (cif.cmd_valid !== 1'b1 || busy !== 1'b1) $display("FAIL latency_edge2: got valid=%b busy=%b, required 1 1", cif.cmd_valid, busy); else n_pass++;
        serve_cmd(0, 3, 32'h12345678, 1, seen, cls, op, dat, st, va, ds, dcls, drd, te, ts);
        n_chk++; if (!seen || cls !== 2'd0 || op !== 2'd1 || dat !== 38'h2A_DEADBEEF) $display("FAIL single_cmd: got seen=%b cls=%0d op=%0d dat=%h, required 1 0 1 2adeadbeef", seen, cls, op, dat); else n_pass++;
        n_chk++; if (va !== 1'b0) $display("FAIL single_valid_drop: got %b, required 0", va); else n_pass++;
        n_chk++; if (ds !== 1'b1 || dcls !== 2'd0 || drd !== 32'h12345678) $display("FAIL single_done: got done=%b cls=%0d rd=%h, required 1 0 12345678", ds, dcls, drd); else n_pass++;
        @(negedge clk);
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL single_done_pulse: got done=%b busy=%b, required 0 0", done, busy); else n_pass++;
        model_retire(0);
    endtask

    task automatic test_multi_class();
        bit seen, st, va, ds, te, ts; logic [1:0] cls, op, dcls; logic [JDO_W-1:0] dat; logic [31:0] drd;
        int exp; int n_done = 0; logic [31:0] rd;
        do_reset();
        apply_strobes(8'hA4, rnd_jdo());
        for (int i = 0; i < 3; i++) begin
            exp = model_next();
            rd  = $urandom();
            serve_cmd(0, 1 + (i % 3), rd, 1, seen, cls, op, dat, st, va, ds, dcls, drd, te, ts);
            n_chk++; if (!seen || exp < 0 || cls !== 2'(exp) || cls !== 2'(i + 1) || op !== m_op[exp] || dat !== m_dat[exp]) $display("FAIL multi_order%0d: got cls=%0d op=%0d dat=%h, required cls=%0d", i, cls, op, dat, exp); else n_pass++;
            if (ds && dcls === 2'(exp) && drd === rd) n_done++;
            model_retire(exp);
        end
        n_chk++; if (n_done !== 3) $display("FAIL multi_done_count: got %0d, required 3", n_done); else n_pass++;
    endtask

    task automatic test_overflow();
        bit seen, st, va, ds, te, ts; logic [1:0] cls, op, dcls; logic [JDO_W-1:0] dat, da, db; logic [31:0] drd;
        da = rnd_jdo(); db = ~da;
        apply_strobes(8'h04, da);
        apply_strobes(8'h08, db);
        n_chk++; if (ovf !== 4'b0010 || ovf !== m_ovf) $display("FAIL ovf_pending: got %b, required 0010", ovf); else n_pass++;
        serve_cmd(1, 2, 32'h0, 1, seen, cls, op, dat, st, va, ds, dcls, drd, te, ts);
        n_chk++; if (!seen || cls !== 2'd1 || op !== 2'd0 || dat !== da) $display("FAIL ovf_orig_payload: got cls=%0d op=%0d dat=%h, required 1 0 %h", cls, op, dat, da); else n_pass++;
        model_retire(1);
        pulse_clr();
        n_chk++; if (ovf !== 4'b0000) $display("FAIL ovf_clear: got %b, required 0000", ovf); else n_pass++;
        clr_status = 1'b1;
        apply_strobes(8'h03, db);
        clr_status = 1'b0;
        n_chk++; if (ovf !== 4'b0001 || ovf !== m_ovf) $display("FAIL ovf_multi_set_wins: got %b, required 0001", ovf); else n_pass++;
        serve_cmd(0, 1, 32'h0, 1, seen, cls, op, dat, st, va, ds, dcls, drd, te, ts);
        n_chk++; if (!seen || cls !== 2'd0 || op !== 2'd0 || dat !== db) $display("FAIL ovf_lowest_suffix: got cls=%0d op=%0d dat=%h, required 0 0 %h", cls, op, dat, db); else n_pass++;
        model_retire(0);
        pulse_clr();
    endtask

    task automatic test_timeout();
        bit seen, st, va, ds, te, ts; logic [1:0] cls, op, dcls; logic [JDO_W-1:0] dat; logic [31:0] drd;
        int e1, e2;
        apply_strobes(8'h41, rnd_jdo());
        e1 = model_next();
        serve_cmd(0, 1, 32'h0, 0, seen, cls, op, dat, st, va, ds, dcls, drd, te, ts);
        n_chk++; if (!seen || cls !== 2'(e1)) $display("FAIL to_first_cls: got %0d, required %0d", cls, e1); else n_pass++;
        n_chk++; if (te !== 1'b0 || ts !== 1'b1) $display("FAIL to_boundary: got at3=%b at4=%b, required 0 1", te, ts); else n_pass++;
        n_chk++; if (ds !== 1'b0 || busy !== 1'b0) $display("FAIL to_no_done_idle: got done=%b busy=%b, required 0 0", ds, busy); else n_pass++;
        model_retire(e1);
        e2 = model_next();
        serve_cmd(0, 2, 32'hCAFE0001, 1, seen, cls, op, dat, st, va, ds, dcls, drd, te, ts);
        n_chk++; if (!seen || e2 < 0 || cls !== 2'(e2) || op !== m_op[e2] || dat !== m_dat[e2] || ds !== 1'b1) $display("FAIL to_next_served: got cls=%0d op=%0d done=%b, required cls=%0d", cls, op, ds, e2); else n_pass++;
        model_retire(e2);
        pulse_clr();
        n_chk++; if (timeout_err !== 1'b0) $display("FAIL to_clear: got %b, required 0", timeout_err); else n_pass++;
    endtask

    task automatic test_ready_stall();
        bit seen, st, va, ds, te, ts; logic [1:0] cls, op, dcls; logic [JDO_W-1:0] dat; logic [31:0] drd;
        int exp;
        apply_strobes(8'(1 << $urandom_range(7, 0)), rnd_jdo());
        exp = model_next();
        serve_cmd(5, 2, 32'h5A5A5A5A, 1, seen, cls, op, dat, st, va, ds, dcls, drd, te, ts);
        n_chk++; if (!seen || st !== 1'b1) $display("FAIL stall_stable: got seen=%b stable=%b, required 1 1", seen, st); else n_pass++;
        n_chk++; if (va !== 1'b0 || exp < 0 || cls !== 2'(exp) || dat !== m_dat[exp] || op !== m_op[exp]) $display("FAIL stall_single_hs: got valid_after=%b cls=%0d, required 0 %0d", va, cls, exp); else n_pass++;
        model_retire(exp);
    endtask

    task automatic test_retire_reload();
        bit seen, st, va, ds, te, ts; logic [1:0] cls, op, dcls; logic [JDO_W-1:0] dat, da, db; logic [31:0] drd;
        int n = 0;
        da = rnd_jdo(); db = rnd_jdo();
        apply_strobes(8'h80, da);
        while (!cif.cmd_valid && n < 20) begin @(negedge clk); n++; end
        n_chk++; if (cif.cmd_valid !== 1'b1 || cif.cmd_data !== da) $display("FAIL reload_first: got valid=%b dat=%h, required 1 %h", cif.cmd_valid, cif.cmd_data, da); else n_pass++;
        cif.cmd_ready = 1'b1;
        @(negedge clk);
        cif.cmd_ready = 1'b0;
        cif.rsp_valid = 1'b1; cif.rsp_rdata = 32'h0BADF00D;
        stb = 8'h80; jdo = db;
        @(negedge clk);
        cif.rsp_valid = 1'b0; stb = '0;
        n_chk++; if (done !== 1'b1 || ovf !== 4'b0000) $display("FAIL reload_no_ovf: got done=%b ovf=%b, required 1 0000", done, ovf); else n_pass++;
        model_retire(3);
        model_strobe(8'h80, db);
        serve_cmd(0, 1, 32'h0, 1, seen, cls, op, dat, st, va, ds, dcls, drd, te, ts);
        n_chk++; if (!seen || cls !== 2'd3 || dat !== db) $display("FAIL reload_new_entry: got cls=%0d dat=%h, required 3 %h", cls, dat, db); else n_pass++;
        model_retire(3);
    endtask

    task automatic test_back_to_back();
        bit seen, st, va, ds, te, ts; logic [1:0] cls, op, dcls; logic [JDO_W-1:0] dat; logic [31:0] drd, rd;
        logic [7:0] s2, mask;
        int exp; int bad;
        for (int r = 0; r < 20; r++) begin
            apply_strobes(8'($urandom()) | 8'h01, rnd_jdo());
            if ($urandom_range(1, 0) == 1) begin
                mask = {{1{m_vld[3]}}, {2{m_vld[2]}}, {3{m_vld[1]}}, {2{m_vld[0]}}};
                s2 = 8'($urandom()) & mask;
                apply_strobes(s2, rnd_jdo());
            end
            n_chk++; if (ovf !== m_ovf) $display("FAIL rand_ovf%0d: got %b, required %b", r, ovf, m_ovf); else n_pass++;
            bad = 0;
            while (model_next() >= 0) begin
                exp = model_next();
                rd  = $urandom();
                serve_cmd($urandom_range(3, 0), $urandom_range(TO, 1), rd, 1, seen, cls, op, dat, st, va, ds, dcls, drd, te, ts);
                if (!seen || cls !== 2'(exp) || op !== m_op[exp] || dat !== m_dat[exp] || !st || va || !ds || dcls !== 2'(exp) || drd !== rd) begin
                    bad++;
                    $display("FAIL rand_cmd%0d: got cls=%0d op=%0d dat=%h done=%b rd=%h, required cls=%0d op=%0d dat=%h rd=%h", r, cls, op, dat, ds, drd, exp, m_op[exp], m_dat[exp], rd);
                end
                model_retire(exp);
            end
            n_chk++; if (bad == 0) n_pass++;
            pulse_clr();
        end
    endtask

    task automatic test_reset_wait();
        int n = 0;
        apply_strobes(8'h04, rnd_jdo());
        while (!cif.cmd_valid && n < 20) begin @(negedge clk); n++; end
        cif.cmd_ready = 1'b1;
        @(negedge clk);
        cif.cmd_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_chk++; if ({cif.cmd_valid, cif.cmd_class, cif.cmd_op, cif.cmd_data, busy} !== '0) $display("FAIL rstwait_cmd: got valid=%b cls=%0d op=%0d dat=%h busy=%b, required 0", cif.cmd_valid, cif.cmd_class, cif.cmd_op, cif.cmd_data, busy); else n_pass++;
        n_chk++; if ({done, done_class, done_rdata, timeout_err, ovf} !== '0) $display("FAIL rstwait_status: got done=%b cls=%0d rd=%h terr=%b ovf=%b, required 0", done, done_class, done_rdata, timeout_err, ovf); else n_pass++;
        cif.rsp_valid = 1'b1; cif.rsp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        cif.rsp_valid = 1'b0;
        repeat (TO + 2) @(negedge clk);
        n_chk++; if ({done, done_rdata, timeout_err, busy, cif.cmd_valid} !== '0) $display("FAIL rstwait_late_rsp: got done=%b rd=%h terr=%b busy=%b valid=%b, required 0", done, done_rdata, timeout_err, busy, cif.cmd_valid); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; stb = '0; jdo = '0; clr_status = 1'b0;
        cif.cmd_ready = 1'b0; cif.rsp_valid = 1'b0; cif.rsp_rdata = '0;
        model_reset();
        test_reset();
        test_single();
        test_multi_class();
        test_overflow();
        test_timeout();
        test_ready_stall();
        test_retire_reload();
        test_back_to_back();
        test_reset_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, required finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_debug_action_sched.md
CPU_DEBUG_ACTION_SCHED -- requirements
Module: cpu_debug_action_sched

Interface
REQ-001 SHALL have parameter JDO_W, default 38, the width of the debug shift-register payload.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before a command is aborted (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port jdo, input, JDO_W bits: the debug payload, sampled with any strobe.
REQ-006 SHALL have inputs take_action_ocimem_a and take_action_ocimem_b, 1 bit each, as single-cycle strobes for class OCIMEM.
REQ-007 SHALL have inputs take_action_break_a, take_action_break_b and take_action_break_c, 1 bit each, as strobes for class BREAK.
REQ-008 SHALL have inputs take_action_tracemem_a and take_action_tracemem_b, 1 bit each, as strobes for class TRACEMEM.
REQ-009 SHALL have input take_action_tracectrl, 1 bit, as the strobe for class TRACECTRL.
REQ-010 SHALL have outputs cmd_valid (1), cmd_class (2), cmd_op (2) and cmd_data (JDO_W), forming the shared-resource command port.
REQ-011 SHALL have input cmd_ready, 1 bit: the resource accepts the command when cmd_valid and cmd_ready are both high.
REQ-012 SHALL have inputs rsp_valid (1) and rsp_rdata (32): the completion pulse and its readback data.
REQ-013 SHALL have outputs done (1), done_class (2), done_rdata (32), timeout_err (1), ovf (4) and busy (1).
REQ-014 SHALL have input clr_status, 1 bit: clears the sticky status bits.

Function
REQ-015 SHALL use class encoding OCIMEM=0, BREAK=1, TRACEMEM=2, TRACECTRL=3.
REQ-016 SHALL use op encoding suffix a=0, b=1, c=2; tracectrl=0.
REQ-017 SHALL give each class a one-entry pending slot holding {valid, op, payload}, with the payload taken from jdo in the strobe cycle.
REQ-018 SHALL, when more than one strobe of a class is high in one cycle, capture the lowest suffix and set that class's ovf bit.
REQ-019 SHALL, on a strobe to a class whose slot is already valid and not being retired this cycle, drop the strobe, set that class's ovf bit and leave the slot unchanged.
REQ-020 SHALL, on a strobe to a class in the same cycle that class's slot is retired, load the new entry and not set ovf.
REQ-021 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-022 SHALL, in IDLE with any slot valid, select a class round-robin starting at rr_ptr+1 (mod 4), latch it, and go to ISSUE next cycle.
REQ-023 SHALL, in ISSUE, hold cmd_valid=1 with class, op and data stable from the selected slot until cmd_ready, then go to WAIT.
REQ-024 SHALL hold cmd_valid=0 outside ISSUE.
REQ-025 SHALL never drop cmd_valid in ISSUE without a handshake.
REQ-026 SHALL, in WAIT, count cycles from 1.
REQ-027 SHALL, on rsp_valid in WAIT: pulse done for one cycle, set done_class to the selected class, register done_rdata=rsp_rdata, retire the slot, set rr_ptr to that class, and return to IDLE.
REQ-028 SHALL, in WAIT with the count reaching TIMEOUT and no rsp_valid: retire the slot, set timeout_err, leave done low, set rr_ptr to that class, and return to IDLE.
REQ-029 SHALL give rsp_valid priority over the timeout when both occur in the same cycle.
REQ-030 SHALL ignore rsp_valid outside WAIT.
REQ-031 SHALL drive busy high in ISSUE and WAIT.
REQ-032 SHALL give a minimum strobe-to-cmd_valid latency of 2 cycles (strobe captured at edge 1; IDLE selects at edge 2; cmd_valid high after edge 2).
REQ-033 SHALL, on clr_status, clear ovf and timeout_err; a set event in the same cycle wins.

Reset
REQ-034 SHALL, on reset, clear all slots, put the FSM in IDLE, set rr_ptr=3 (so OCIMEM is first), and zero the WAIT counter.
REQ-035 SHALL, on reset, drive cmd_valid=0, cmd_class=0, cmd_op=0, cmd_data=0, done=0, done_class=0, done_rdata=0, timeout_err=0, ovf=0 and busy=0.
REQ-036 SHALL, on reset mid-ISSUE or mid-WAIT, abandon the command with no done and no error.
REQ-037 SHALL ignore strobes in the reset cycle.

Structure
REQ-038 SHALL place the class and op encodings, the FSM state type and the TIMEOUT default in a shared package, cpu_debug_pkg.
REQ-039 SHALL implement the round-robin selector as one sub-module, cpu_debug_rr_arb: 4-bit request vector plus pointer in, one-hot grant and encoded index out, combinational.

Verification
REQ-040 SHALL cover: take_action_ocimem_b with jdo=0x2A_DEADBEEF, cmd_ready=1, rsp after 3 cycles with rdata 0x12345678 -> cmd class 0, op 1, data 0x2A_DEADBEEF; done with done_rdata 0x12345678.
REQ-041 SHALL cover: the break_a, tracemem_a and tracectrl strobes in one cycle after reset -> grants in order BREAK, TRACEMEM, TRACECTRL with three done pulses.
REQ-042 SHALL cover: a second take_action_break_b while the BREAK slot is pending -> ovf=4'b0010 and the original payload issued; clr_status -> ovf=0.
REQ-043 SHALL cover: TIMEOUT=4 with rsp_valid withheld -> timeout_err=1 after 4 WAIT cycles, no done, FSM in IDLE, next class served.
REQ-044 SHALL cover: cmd_ready low for 5 cycles -> cmd_valid and its payload held stable, then a single handshake.
REQ-045 SHALL cover: reset asserted during WAIT -> all outputs zero next cycle; a late rsp_valid is ignored.
